in_fm_ld_counter: RTL and testbench



---
 rtl/in_fm_ld_counter_if.sv | 31 +++
 rtl/in_fm_ld_counter.sv | 167 ++++++++++++++++
 tb/tb_in_fm_ld_counter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/in_fm_ld_counter_if.sv
// Read-request channel between the input-FM load counter and the DRAM read port.
// The master drives the address and tile indices; the slave returns req_ready.
interface in_fm_ld_counter_if #(
    parameter int CW = 16,
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic          req_last;

    modport master (
        output req_valid,
        output req_addr,
        output cnt0,
        output cnt1,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  cnt0,
        input  cnt1,
        input  req_last,
        output req_ready
    );
endinterface

// File: rtl/in_fm_ld_counter.sv
// Walks an n1 x n0 input-FM tile in row-major order, issuing one read request
// per element, and pulses done once the last request has been accepted.
//
// state | meaning
// IDLE  | waiting for load_start; no requests outstanding
// RUN   | presenting req_valid; indices advance on each accept
// FIN   | tile complete; done pulses for one cycle, then back to IDLE
module in_fm_ld_counter #(
    parameter int CW = 16,
    parameter int AW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_start,
    input  logic                clean,
    input  logic [CW-1:0]       n0_max,
    input  logic [CW-1:0]       n1_max,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW-1:0]       row_stride,
    in_fm_ld_counter_if.master  req,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] n0_q, n0_d;
    logic [CW-1:0] n1_q, n1_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt0_q, cnt0_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          accept;
    logic          col_end;
    logic          row_end;
    logic [CW-1:0] n0_m1;
    logic [CW-1:0] n1_m1;
    logic [AW-1:0] next_row_base;

    assign accept        = valid_q && req.req_ready;
    assign n0_m1         = n0_q - CW'(1);
    assign n1_m1         = n1_q - CW'(1);
    assign col_end       = (cnt0_q == n0_m1);
    assign row_end       = (cnt1_q == n1_m1);
    assign next_row_base = row_base_q + stride_q;

    always_comb begin
        state_d    = state_q;
        n0_d       = n0_q;
        n1_d       = n1_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        if (clean) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt0_d  = '0;
            cnt1_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        n0_d       = n0_max;
                        n1_d       = n1_max;
                        stride_d   = row_stride;
                        row_base_d = base_addr;
                        addr_d     = base_addr;
                        cnt0_d     = '0;
                        cnt1_d     = '0;
                        if ((n0_max == '0) || (n1_max == '0)) begin
                            state_d = FIN;
                        end else begin
                            state_d = RUN;
                            valid_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!col_end) begin
                            cnt0_d = cnt0_q + CW'(1);
                            addr_d = addr_q + AW'(1);
                        end else if (!row_end) begin
                            cnt0_d     = '0;
                            cnt1_d     = cnt1_q + CW'(1);
                            row_base_d = next_row_base;
                            addr_d     = next_row_base;
                        end else begin
                            valid_d = 1'b0;
                            cnt0_d  = '0;
                            cnt1_d  = '0;
                            done_d  = 1'b1;
                            state_d = FIN;
                        end
                    end
                end
                FIN: begin
                    // A walk arrives here with done already raised; a zero-size
                    // tile arrives without it and raises it one cycle later.
                    if (done_q) begin
                        state_d = IDLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n0_q       <= '0;
            n1_q       <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n0_q       <= n0_d;
            n1_q       <= n1_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign req.req_valid = valid_q;
    assign req.req_addr  = addr_q;
    assign req.cnt0      = cnt0_q;
    assign req.cnt1      = cnt1_q;
    assign req.req_last  = valid_q && col_end && row_end;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_in_fm_ld_counter.sv
// Randomised scoreboard bench for in_fm_ld_counter: expected request beats are
// queued from a row-major tile model and popped by a monitor on every accept.
module tb_in_fm_ld_counter;
    localparam int CW = 16;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          clean = 1'b0;
    logic [CW-1:0] n0_max = '0;
    logic [CW-1:0] n1_max = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] row_stride = '0;
    logic          busy;
    logic          done;

    in_fm_ld_counter_if #(.CW(CW), .AW(AW)) rif ();

    in_fm_ld_counter #(.CW(CW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .clean      (clean),
        .n0_max     (n0_max),
        .n1_max     (n1_max),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .req        (rif.master),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
        logic          last;
    } beat_t;

    beat_t         sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            acc_cnt = 0;
    int            start_cyc = 0;
    int            last_acc_cyc = 0;
    int            ready_mode = 0;
    bit            done_pending = 0;
    bit            exp_zero = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [CW-1:0] prev_c0 = '0;
    logic [CW-1:0] prev_c1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard on every accept and checks done timing.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", rif.req_valid, 1);
                chk("stall_addr", rif.req_addr, prev_addr);
                chk("stall_cnt0", rif.cnt0, prev_c0);
                chk("stall_cnt1", rif.cnt1, prev_c1);
            end
            if (rif.req_valid && rif.req_ready) begin
                if (sb.size() == 0) begin
                    flag("unexpected_request");
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("req_addr", rif.req_addr, b.addr);
                    chk("cnt0", rif.cnt0, b.c0);
                    chk("cnt1", rif.cnt1, b.c1);
                    chk("req_last", rif.req_last, b.last);
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (done) begin
                if (!done_pending) begin
                    flag("spurious_done");
                end else begin
                    chk("done_queue_empty", sb.size(), 0);
                    chk("done_cycle", cyc, exp_zero ? start_cyc + 2 : last_acc_cyc + 1);
                    chk("busy_at_done", busy, 1);
                    done_pending = 0;
                end
            end
            prev_stall = rif.req_valid && !rif.req_ready && !clean;
            prev_addr  = rif.req_addr;
            prev_c0    = rif.cnt0;
            prev_c1    = rif.cnt1;
        end
    end

    // Downstream ready: always-on, 1,0,0 pattern, or random.
    initial begin
        int phase = 0;
        rif.req_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: rif.req_ready = 1'b1;
                1: begin
                    rif.req_ready = (phase % 3 == 0);
                    phase++;
                end
                default: rif.req_ready = 1'(($urandom_range(0, 1)));
            endcase
        end
    end

    task automatic start_tile(input int n0, input int n1, input logic [AW-1:0] base,
                              input logic [AW-1:0] stride);
        sb.delete();
        for (int r = 0; r < n1; r++) begin
            for (int c = 0; c < n0; c++) begin
                beat_t b;
                b.addr = base + stride * AW'(r) + AW'(c);
                b.c0   = CW'(c);
                b.c1   = CW'(r);
                b.last = (r == n1 - 1) && (c == n0 - 1);
                sb.push_back(b);
            end
        end
        exp_zero     = (n0 == 0) || (n1 == 0);
        done_pending = 1;
        acc_cnt      = 0;
        @(posedge clk);
        #1;
        n0_max     = CW'(n0);
        n1_max     = CW'(n1);
        base_addr  = base;
        row_stride = stride;
        load_start = 1'b1;
        start_cyc  = cyc;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        n0_max     = CW'($urandom_range(0, 7));
        n1_max     = CW'($urandom_range(0, 7));
        base_addr  = $urandom;
        row_stride = $urandom;
        @(negedge clk);
        chk("valid_after_start", rif.req_valid, !exp_zero);
        chk("busy_after_start", busy, 1);
        if (!exp_zero) chk("addr_after_start", rif.req_addr, base);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_pending && k < 400) begin
            @(posedge clk);
            k++;
        end
        if (done_pending) begin
            flag("done_timeout");
            done_pending = 0;
            sb.delete();
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_valid", rif.req_valid, 0);
    endtask

    initial begin
        #2;
        chk("rst_valid", rif.req_valid, 0);
        chk("rst_addr", rif.req_addr, 0);
        chk("rst_cnt0", rif.cnt0, 0);
        chk("rst_cnt1", rif.cnt1, 0);
        chk("rst_last", rif.req_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        ready_mode = 0;
        start_tile(4, 3, 32'h100, 32'h20);
        wait_done();

        ready_mode = 1;
        start_tile(4, 3, 32'h100, 32'h20);
        wait_done();

        ready_mode = 0;
        start_tile(0, 3, 32'h200, 32'h10);
        wait_done();
        start_tile(5, 0, 32'h200, 32'h10);
        wait_done();

        // Abort after the fifth accept, then restart from base.
        ready_mode = 0;
        start_tile(4, 3, 32'h100, 32'h20);
        begin
            int k = 0;
            while (acc_cnt < 5 && k < 100) begin
                @(posedge clk);
                k++;
            end
        end
        #1;
        clean = 1'b1;
        @(posedge clk);
        #1;
        clean = 1'b0;
        done_pending = 0;
        @(negedge clk);
        chk("clean_acc_count", acc_cnt, 6);
        chk("clean_valid", rif.req_valid, 0);
        chk("clean_cnt0", rif.cnt0, 0);
        chk("clean_cnt1", rif.cnt1, 0);
        chk("clean_busy", busy, 0);
        sb.delete();
        repeat (5) @(posedge clk);
        start_tile(4, 3, 32'h100, 32'h20);
        wait_done();

        // A second load_start mid-walk must be ignored.
        ready_mode = 1;
        start_tile(4, 3, 32'h100, 32'h20);
        repeat (4) @(posedge clk);
        #1;
        load_start = 1'b1;
        base_addr  = 32'h9000;
        n0_max     = 16'd2;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        wait_done();

        ready_mode = 0;
        start_tile(4, 1, 32'hFFFF_FFFE, 32'h0);
        wait_done();

        // Asynchronous reset in the middle of a walk.
        start_tile(4, 3, 32'h500, 32'h40);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", rif.req_valid, 0);
        chk("arst_addr", rif.req_addr, 0);
        chk("arst_cnt0", rif.cnt0, 0);
        chk("arst_cnt1", rif.cnt1, 0);
        chk("arst_last", rif.req_last, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        done_pending = 0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        ready_mode = 2;
        for (int t = 0; t < 8; t++) begin
            start_tile(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), $urandom, $urandom);
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
